entrada_dados_seq: RTL and testbench



---
 rtl/entrada_dados_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_entrada_dados_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/entrada_dados_seq.sv
// Frame sequencer and FIFO in front of the RANSAC NIOS point-input port, drained through an Avalon-MM slave.
// Optional level interrupt (irq port, CONTROL[4] IRQ_EN) is compiled in with `define ENTRADA_SEQ_IRQ_EN.
module entrada_dados_seq #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int DEFAULT_LEN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
`ifdef ENTRADA_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_LEN     = 2'd3;

  state_t        state_q, state_d;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [8:0]    captured_q;
  logic [8:0]    len_q;
  logic [8:0]    len_wr;
  logic          overflow_q;
  logic          empty, full;
  logic          wr_ctrl, wr_len;
  logic          pop_cmd, start_cmd, flush_cmd, clr_ovf_cmd;
  logic          push, pop_ok, underflow;
  logic          last_word;
  logic [31:0]   rd_mux;
  logic          irq_en_bit;

  // Readdata is refreshed every cycle from the address alone, so the strobe carries no information.
  logic          unused_read;
  assign unused_read = read;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  assign wr_ctrl     = write && (address == ADDR_CONTROL);
  assign wr_len      = write && (address == ADDR_LEN) && (state_q != CAPTURE);
  assign pop_cmd     = wr_ctrl && writedata[0];
  assign start_cmd   = wr_ctrl && writedata[1];
  assign flush_cmd   = wr_ctrl && writedata[2];
  assign clr_ovf_cmd = wr_ctrl && writedata[3];

  // Flush dominates everything: a word handshaked in the flush cycle is discarded with the frame.
  assign push      = in_valid && in_ready && !flush_cmd;
  assign pop_ok    = pop_cmd && !empty && !flush_cmd;
  assign underflow = pop_cmd && empty && !flush_cmd;
  assign last_word = ((captured_q + 9'd1) == len_q);

  always_comb begin
    len_wr = writedata[8:0];
    if (writedata == 32'd0) begin
      len_wr = 9'd1;
    end else if (writedata > 32'(DEPTH)) begin
      len_wr = 9'(DEPTH);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_cmd) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        in_ready = !full;
        if (push && last_word) begin
          state_d = READY;
        end
      end
      READY: begin
        if (pop_ok && (count_q == (AW+1)'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_cmd) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      captured_q <= '0;
    end else if (flush_cmd) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      captured_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (start_cmd && (state_q == IDLE)) begin
        captured_q <= '0;
      end else if (push) begin
        captured_q <= captured_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q      <= 9'(DEFAULT_LEN);
      overflow_q <= 1'b0;
    end else begin
      if (wr_len) begin
        len_q <= len_wr;
      end
      if (underflow) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf_cmd) begin
        overflow_q <= 1'b0;
      end
    end
  end

`ifdef ENTRADA_SEQ_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en_q <= writedata[4];
      end
      irq <= irq_en_q && ((state_q == READY) || overflow_q);
    end
  end

  assign irq_en_bit = irq_en_q;
`else
  assign irq_en_bit = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: begin
        if (!empty) begin
          rd_mux = mem[rd_ptr_q];
        end
      end
      ADDR_STATUS: begin
        rd_mux[0]    = empty;
        rd_mux[1]    = full;
        rd_mux[2]    = (state_q == READY);
        rd_mux[3]    = overflow_q;
        rd_mux[4]    = (state_q == CAPTURE);
        rd_mux[5]    = irq_en_bit;
        rd_mux[15:8] = 8'(count_q);
      end
      ADDR_LEN: begin
        rd_mux[8:0] = len_q;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_entrada_dados_seq.sv
// Directed bench for entrada_dados_seq (DEPTH=16, DEFAULT_LEN=8); irq scenario built with ENTRADA_SEQ_IRQ_EN.
module tb_entrada_dados_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
`ifdef ENTRADA_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  entrada_dados_seq #(.DEPTH(16), .AW(4), .DEFAULT_LEN(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready)
`ifdef ENTRADA_SEQ_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  task automatic avalon_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic avalon_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    d = readdata;
  endtask

  // Offers words base, base+1, ...; leaves in_valid asserted if the budget ran out with a word pending.
  task automatic stream_words(input int n, input logic [31:0] base, input int budget, output int sent);
    logic acc;
    sent = 0;
    for (int c = 0; c < budget && sent < n; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = base + 32'(sent);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    if (sent == n) in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (readdata !== 32'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs readdata=%h in_ready=%b required 0/0", readdata, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL reset_status got=%h required=%h", d, 32'h1);
    end
    avalon_read(2'd3, d);
    checks++;
    if (d !== 32'd8) begin
      failures++;
      $display("[TB] FAIL reset_len got=%0d required=8", d);
    end
    avalon_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h required=0", d);
    end
  endtask

  task automatic test_short_frame();
    logic [31:0] d;
    int sent;
    avalon_write(2'd3, 32'd3);
    avalon_read(2'd3, d);
    checks++;
    if (d !== 32'd3) begin
      failures++;
      $display("[TB] FAIL len3 got=%0d required=3", d);
    end
    avalon_write(2'd2, 32'h2);
    stream_words(4, 32'hA1, 8, sent);
    checks++;
    if (sent !== 3 || in_ready !== 1'b0 || in_valid !== 1'b1 || in_data !== 32'hA4) begin
      failures++;
      $display("[TB] FAIL frame3_accept sent=%0d in_ready=%b held=%h required 3/0/a4", sent, in_ready, in_data);
    end
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h304) begin
      failures++;
      $display("[TB] FAIL frame3_status got=%h required=%h", d, 32'h304);
    end
    in_valid = 1'b0;
    avalon_read(2'd0, d);
    checks++;
    if (d !== 32'hA1) begin
      failures++;
      $display("[TB] FAIL data_a1 got=%h required=a1", d);
    end
    avalon_read(2'd0, d);
    checks++;
    if (d !== 32'hA1) begin
      failures++;
      $display("[TB] FAIL data_read_no_pop got=%h required=a1", d);
    end
    avalon_write(2'd2, 32'h1);
    avalon_read(2'd0, d);
    checks++;
    if (d !== 32'hA2) begin
      failures++;
      $display("[TB] FAIL data_a2 got=%h required=a2", d);
    end
    avalon_write(2'd2, 32'h1);
    avalon_write(2'd2, 32'h1);
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL drained_status got=%h required=1", d);
    end
    avalon_write(2'd2, 32'h1);
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h9) begin
      failures++;
      $display("[TB] FAIL underflow_status got=%h required=9", d);
    end
    avalon_write(2'd2, 32'h8);
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL clr_overflow got=%h required=1", d);
    end
  endtask

  task automatic test_len_clamp();
    logic [31:0] d;
    avalon_write(2'd3, 32'd0);
    avalon_read(2'd3, d);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("[TB] FAIL len_zero got=%0d required=1", d);
    end
    avalon_write(2'd3, 32'd40);
    avalon_read(2'd3, d);
    checks++;
    if (d !== 32'd16) begin
      failures++;
      $display("[TB] FAIL len_clamp got=%0d required=16", d);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] d;
    int sent;
    int bad;
    avalon_write(2'd2, 32'h2);
    stream_words(16, 32'd0, 40, sent);
    avalon_read(2'd1, d);
    checks++;
    if (sent !== 16 || d !== 32'h1006) begin
      failures++;
      $display("[TB] FAIL full_status sent=%0d status=%h required 16/1006", sent, d);
    end
    avalon_read(2'd0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("[TB] FAIL full_head got=%0d required=0", d);
    end
    avalon_write(2'd2, 32'h1);
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h0F04) begin
      failures++;
      $display("[TB] FAIL pop_one_status got=%h required=0f04", d);
    end
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      avalon_read(2'd0, d);
      if (d !== 32'(i)) bad++;
      avalon_write(2'd2, 32'h1);
    end
    avalon_read(2'd1, d);
    checks++;
    if (bad != 0 || d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL frame_a_order bad_words=%0d status=%h required 0/1", bad, d);
    end
    avalon_write(2'd2, 32'h2);
    stream_words(16, 32'd16, 40, sent);
    bad = 0;
    for (int i = 16; i < 32; i++) begin
      avalon_read(2'd0, d);
      if (d !== 32'(i)) bad++;
      avalon_write(2'd2, 32'h1);
    end
    avalon_read(2'd1, d);
    checks++;
    if (sent !== 16 || bad != 0 || d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL frame_b_wrap sent=%0d bad_words=%0d status=%h required 16/0/1", sent, bad, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int sent;
    avalon_write(2'd3, 32'd4);
    avalon_write(2'd2, 32'h2);
    stream_words(1, 32'h11, 8, sent);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'h22;
    address = 2'd2;
    writedata = 32'h1;
    write = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    write = 1'b0;
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h110) begin
      failures++;
      $display("[TB] FAIL push_pop_status got=%h required=110", d);
    end
    avalon_read(2'd0, d);
    checks++;
    if (d !== 32'h22) begin
      failures++;
      $display("[TB] FAIL push_pop_head got=%h required=22", d);
    end
    avalon_write(2'd3, 32'd9);
    avalon_read(2'd3, d);
    checks++;
    if (d !== 32'd4) begin
      failures++;
      $display("[TB] FAIL len_locked got=%0d required=4", d);
    end
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] d;
    int sent;
    avalon_write(2'd2, 32'h4);
    avalon_write(2'd3, 32'd5);
    avalon_write(2'd2, 32'h2);
    stream_words(2, 32'h50, 8, sent);
    avalon_write(2'd2, 32'h4);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_in_ready got=%b required=0", in_ready);
    end
    avalon_read(2'd1, d);
    checks++;
    if (sent !== 2 || d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL flush_status sent=%0d status=%h required 2/1", sent, d);
    end
    avalon_write(2'd2, 32'h2);
    stream_words(2, 32'h60, 8, sent);
    avalon_read(2'd1, d);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || readdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL async_reset in_ready=%b readdata=%h required 0/0", in_ready, readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL post_reset_status got=%h required=1", d);
    end
    avalon_read(2'd3, d);
    checks++;
    if (d !== 32'd8) begin
      failures++;
      $display("[TB] FAIL post_reset_len got=%0d required=8", d);
    end
  endtask

`ifdef ENTRADA_SEQ_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    int sent;
    avalon_write(2'd2, 32'h10);
    avalon_read(2'd1, d);
    checks++;
    if (d !== 32'h21 || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_en_status got=%h irq=%b required 21/0", d, irq);
    end
    avalon_write(2'd3, 32'd2);
    avalon_write(2'd2, 32'h12);
    stream_words(2, 32'h70, 8, sent);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_early got=%b required=0", irq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL irq_ready got=%b required=1", irq);
    end
    avalon_write(2'd2, 32'h11);
    avalon_write(2'd2, 32'h11);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_drained got=%b required=0", irq);
    end
    avalon_write(2'd2, 32'h11);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL irq_underflow got=%b required=1", irq);
    end
    avalon_write(2'd2, 32'h18);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_cleared got=%b required=0", irq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_short_frame();
    test_len_clamp();
    test_full_wrap();
    test_back_to_back();
    test_flush_and_reset();
`ifdef ENTRADA_SEQ_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
